// File: rtl/axis_test_pkg.sv
// Shared helpers for the AXI-Stream test FIFO: packed-entry sizing and
// address-width computation used by the top level and its RAM.
package axis_test_pkg;

    // tdata always sits at the bottom of a stored entry
    localparam int DATA_OFFSET = 0;

    // Address width for a storage array, never narrower than one bit
    function automatic int clog2w(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

    // Width a sideband field occupies in storage (zero when not carried)
    function automatic int field_w(input int enable, input int width);
        return (enable != 0) ? width : 0;
    endfunction

    // Total packed-entry width: tdata plus every enabled sideband
    function automatic int entry_width(
        input int dataWidth,
        input int keepEnable, input int keepWidth,
        input int lastEnable,
        input int idEnable,   input int idWidth,
        input int destEnable, input int destWidth,
        input int userEnable, input int userWidth
    );
        return dataWidth
             + field_w(keepEnable, keepWidth)
             + field_w(lastEnable, 1)
             + field_w(idEnable, idWidth)
             + field_w(destEnable, destWidth)
             + field_w(userEnable, userWidth);
    endfunction

endpackage

// File: rtl/axis_test_fifo_ram.sv
// Simple dual-port storage for the stream FIFO: registered write port,
// combinational read port so the head entry is visible without latency.
module axis_test_fifo_ram #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Store the incoming entry on an accepted beat
    always_ff @(posedge i_clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/axis_test_fifo.sv
// AXI4-Stream FIFO with optional sidebands and optional frame gating.
// Holds the pointers, status counters, handshake logic and field packing;
// the payload itself lives in axis_test_fifo_ram.
module axis_test_fifo
    import axis_test_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_ENABLE = (DATA_WIDTH > 8) ? 1 : 0,
    parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
    parameter int LAST_ENABLE = 1,
    parameter int ID_ENABLE   = 0,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_ENABLE = 0,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_ENABLE = 1,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 16,
    parameter int FRAME_FIFO  = 0,
    localparam int ST_W       = clog2w(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic [ST_W-1:0]       status_depth,
    output logic [ST_W-1:0]       status_frames,
    output logic                  status_good_frame
);

    localparam int ADDR_W   = clog2w(DEPTH);
    localparam int PTR_W    = ADDR_W + 1;
    localparam int KEEP_OFF = DATA_OFFSET + DATA_WIDTH;
    localparam int LAST_OFF = KEEP_OFF + field_w(KEEP_ENABLE, KEEP_WIDTH);
    localparam int ID_OFF   = LAST_OFF + field_w(LAST_ENABLE, 1);
    localparam int DEST_OFF = ID_OFF + field_w(ID_ENABLE, ID_WIDTH);
    localparam int USER_OFF = DEST_OFF + field_w(DEST_ENABLE, DEST_WIDTH);
    localparam int ENTRY_W  = entry_width(DATA_WIDTH, KEEP_ENABLE, KEEP_WIDTH,
                                          LAST_ENABLE, ID_ENABLE, ID_WIDTH,
                                          DEST_ENABLE, DEST_WIDTH,
                                          USER_ENABLE, USER_WIDTH);

    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_depth;
    logic [PTR_W-1:0]   r_frames;
    logic               r_goodFrame;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_inLast;
    logic               w_frameIn;
    logic               w_frameOut;
    logic [ENTRY_W-1:0] w_wrEntry;
    logic [ENTRY_W-1:0] w_rdEntry;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_full  = (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]) &&
                     (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]);
    assign w_empty = (r_wrPtr == r_rdPtr);

    // A full buffer also releases output so frames longer than DEPTH cut through
    assign s_axis_tready = !w_full && !rst;
    assign m_axis_tvalid = !w_empty && !rst &&
                           ((FRAME_FIFO == 0) || (r_frames != '0) || w_full);

    assign w_push     = s_axis_tvalid && s_axis_tready;
    assign w_pop      = m_axis_tvalid && m_axis_tready;
    assign w_frameIn  = w_push && w_inLast;
    assign w_frameOut = w_pop && m_axis_tlast;

    assign w_wrEntry[DATA_OFFSET +: DATA_WIDTH] = s_axis_tdata;
    assign m_axis_tdata = w_rdEntry[DATA_OFFSET +: DATA_WIDTH];

    if (KEEP_ENABLE != 0) begin : g_keep
        assign w_wrEntry[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep = w_rdEntry[KEEP_OFF +: KEEP_WIDTH];
    end else begin : g_noKeep
        logic w_unusedKeep;
        assign w_unusedKeep = ^s_axis_tkeep;
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign w_wrEntry[LAST_OFF] = s_axis_tlast;
        assign w_inLast            = s_axis_tlast;
        assign m_axis_tlast        = w_rdEntry[LAST_OFF];
    end else begin : g_noLast
        logic w_unusedLast;
        assign w_unusedLast = s_axis_tlast;
        assign w_inLast     = 1'b1;
        assign m_axis_tlast = 1'b1;
    end

    if (ID_ENABLE != 0) begin : g_id
        assign w_wrEntry[ID_OFF +: ID_WIDTH] = s_axis_tid;
        assign m_axis_tid = w_rdEntry[ID_OFF +: ID_WIDTH];
    end else begin : g_noId
        logic w_unusedId;
        assign w_unusedId = ^s_axis_tid;
        assign m_axis_tid = '0;
    end

    if (DEST_ENABLE != 0) begin : g_dest
        assign w_wrEntry[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
        assign m_axis_tdest = w_rdEntry[DEST_OFF +: DEST_WIDTH];
    end else begin : g_noDest
        logic w_unusedDest;
        assign w_unusedDest = ^s_axis_tdest;
        assign m_axis_tdest = '0;
    end

    if (USER_ENABLE != 0) begin : g_user
        assign w_wrEntry[USER_OFF +: USER_WIDTH] = s_axis_tuser;
        assign m_axis_tuser = w_rdEntry[USER_OFF +: USER_WIDTH];
    end else begin : g_noUser
        logic w_unusedUser;
        assign w_unusedUser = ^s_axis_tuser;
        assign m_axis_tuser = '0;
    end

    axis_test_fifo_ram #(
        .DEPTH  (DEPTH),
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk    (clk),
        .i_wrEn   (w_push),
        .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
        .i_wrData (w_wrEntry),
        .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
        .o_rdData (w_rdEntry)
    );

    // Advance write and read pointers on accepted and delivered beats
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
        end
    end

    // Stored-beat count; a simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_depth <= r_depth + PTR_W'(1);
                2'b01:   r_depth <= r_depth - PTR_W'(1);
                default: r_depth <= r_depth;
            endcase
        end
    end

    // Complete-frame count plus the pulse marking a delivered frame end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frames    <= '0;
            r_goodFrame <= 1'b0;
        end else begin
            case ({w_frameIn, w_frameOut})
                2'b10:   r_frames <= r_frames + PTR_W'(1);
                2'b01:   r_frames <= r_frames - PTR_W'(1);
                default: r_frames <= r_frames;
            endcase
            r_goodFrame <= w_frameOut;
        end
    end

    assign status_depth      = r_depth;
    assign status_frames     = r_frames;
    assign status_good_frame = r_goodFrame;

endmodule

// File: tb/tb_axis_test_fifo.sv
// Directed bench for axis_test_fifo. Instance A is a plain FIFO with every
// sideband enabled on 16-bit data; instance B is a frame FIFO with default
// 8-bit data and the tid/tdest/tkeep fields disabled.
module tb_axis_test_fifo;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
        logic        user;
    } beat_t;

    logic [15:0] aSdata;  logic [1:0] aSkeep;  logic aSvalid, aSready, aSlast;
    logic [7:0]  aSid, aSdest;  logic aSuser;
    logic [15:0] aMdata;  logic [1:0] aMkeep;  logic aMvalid, aMready, aMlast;
    logic [7:0]  aMid, aMdest;  logic aMuser;
    logic [4:0]  aDepth, aFrames;  logic aGood;

    logic [7:0]  bSdata;  logic bSkeep;  logic bSvalid, bSready, bSlast;
    logic [7:0]  bSid, bSdest;  logic bSuser;
    logic [7:0]  bMdata;  logic bMkeep;  logic bMvalid, bMready, bMlast;
    logic [7:0]  bMid, bMdest;  logic bMuser;
    logic [4:0]  bDepth, bFrames;  logic bGood;

    int total = 0;
    int bad   = 0;
    int goodA = 0;
    int goodB = 0;
    beat_t txA[$], rxA[$], txB[$], rxB[$];

    axis_test_fifo #(
        .DATA_WIDTH(16), .KEEP_ENABLE(1), .LAST_ENABLE(1),
        .ID_ENABLE(1), .ID_WIDTH(8), .DEST_ENABLE(1), .DEST_WIDTH(8),
        .USER_ENABLE(1), .USER_WIDTH(1), .DEPTH(16), .FRAME_FIFO(0)
    ) dutA (
        .clk(clk), .rst(rst),
        .s_axis_tdata(aSdata), .s_axis_tkeep(aSkeep), .s_axis_tvalid(aSvalid),
        .s_axis_tready(aSready), .s_axis_tlast(aSlast), .s_axis_tid(aSid),
        .s_axis_tdest(aSdest), .s_axis_tuser(aSuser),
        .m_axis_tdata(aMdata), .m_axis_tkeep(aMkeep), .m_axis_tvalid(aMvalid),
        .m_axis_tready(aMready), .m_axis_tlast(aMlast), .m_axis_tid(aMid),
        .m_axis_tdest(aMdest), .m_axis_tuser(aMuser),
        .status_depth(aDepth), .status_frames(aFrames), .status_good_frame(aGood)
    );

    axis_test_fifo #(
        .DATA_WIDTH(8), .DEPTH(16), .FRAME_FIFO(1)
    ) dutB (
        .clk(clk), .rst(rst),
        .s_axis_tdata(bSdata), .s_axis_tkeep(bSkeep), .s_axis_tvalid(bSvalid),
        .s_axis_tready(bSready), .s_axis_tlast(bSlast), .s_axis_tid(bSid),
        .s_axis_tdest(bSdest), .s_axis_tuser(bSuser),
        .m_axis_tdata(bMdata), .m_axis_tkeep(bMkeep), .m_axis_tvalid(bMvalid),
        .m_axis_tready(bMready), .m_axis_tlast(bMlast), .m_axis_tid(bMid),
        .m_axis_tdest(bMdest), .m_axis_tuser(bMuser),
        .status_depth(bDepth), .status_frames(bFrames), .status_good_frame(bGood)
    );

    function automatic beat_t mk(input logic [15:0] d, input logic [1:0] k, input logic l,
                                 input logic [7:0] id, input logic [7:0] dest, input logic u);
        beat_t b;
        b.data = d; b.keep = k; b.last = l; b.id = id; b.dest = dest; b.user = u;
        return b;
    endfunction

    // One clock of instance A: offer the head of txA, record handshakes at negedge
    task automatic cycleA(input bit offer, input bit ready);
        beat_t b;
        if (offer && txA.size() != 0) begin
            b = txA[0];
            aSvalid = 1'b1; aSdata = b.data; aSkeep = b.keep; aSlast = b.last;
            aSid = b.id; aSdest = b.dest; aSuser = b.user;
        end else begin
            aSvalid = 1'b0;
        end
        aMready = ready;
        @(negedge clk);
        if (aGood) goodA++;
        if (aSvalid && aSready) b = txA.pop_front();
        if (aMvalid && aMready) rxA.push_back('{aMdata, aMkeep, aMlast, aMid, aMdest, aMuser});
        @(posedge clk); #1;
    endtask

    // One clock of instance B; disabled inputs are driven with junk on purpose
    task automatic cycleB(input bit offer, input bit ready);
        beat_t b;
        if (offer && txB.size() != 0) begin
            b = txB[0];
            bSvalid = 1'b1; bSdata = b.data[7:0]; bSlast = b.last; bSuser = b.user;
        end else begin
            bSvalid = 1'b0;
        end
        bSkeep = 1'b0; bSid = 8'hA5; bSdest = 8'h5A;
        bMready = ready;
        @(negedge clk);
        if (bGood) goodB++;
        if (bSvalid && bSready) b = txB.pop_front();
        if (bMvalid && bMready) rxB.push_back('{{8'h00, bMdata}, {1'b0, bMkeep}, bMlast, bMid, bMdest, bMuser});
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (aSready !== 1'b0) begin bad++; $display("FAIL reset_a_tready got=%b want=0", aSready); end
        total++; if (aMvalid !== 1'b0) begin bad++; $display("FAIL reset_a_tvalid got=%b want=0", aMvalid); end
        total++; if (aDepth !== 5'd0) begin bad++; $display("FAIL reset_a_depth got=%0d want=0", aDepth); end
        total++; if (aFrames !== 5'd0) begin bad++; $display("FAIL reset_a_frames got=%0d want=0", aFrames); end
        total++; if (aGood !== 1'b0) begin bad++; $display("FAIL reset_a_good got=%b want=0", aGood); end
        total++; if (bSready !== 1'b0) begin bad++; $display("FAIL reset_b_tready got=%b want=0", bSready); end
        total++; if (bMvalid !== 1'b0) begin bad++; $display("FAIL reset_b_tvalid got=%b want=0", bMvalid); end
        rst = 1'b0;
        #1;
        total++; if (aSready !== 1'b1) begin bad++; $display("FAIL release_a_tready got=%b want=1", aSready); end
        total++; if (bSready !== 1'b1) begin bad++; $display("FAIL release_b_tready got=%b want=1", bSready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_frame();
        beat_t e;
        rxA.delete(); goodA = 0;
        for (int i = 0; i < 8; i++) txA.push_back(mk(16'(i), 2'b11, (i == 7), 8'h00, 8'h00, 1'b0));
        cycleA(1'b1, 1'b0);
        total++; if (aMvalid !== 1'b1) begin bad++; $display("FAIL latency_tvalid got=%b want=1", aMvalid); end
        total++; if (aDepth !== 5'd1) begin bad++; $display("FAIL latency_depth got=%0d want=1", aDepth); end
        for (int c = 0; c < 40 && rxA.size() < 8; c++) cycleA(1'b1, 1'b1);
        cycleA(1'b0, 1'b1);
        total++; if (rxA.size() != 8) begin bad++; $display("FAIL single_count got=%0d want=8", rxA.size()); end
        for (int i = 0; i < rxA.size() && i < 8; i++) begin
            e = mk(16'(i), 2'b11, (i == 7), 8'h00, 8'h00, 1'b0);
            total++; if (rxA[i] !== e) begin bad++; $display("FAIL single_beat[%0d] got=%h want=%h", i, rxA[i], e); end
        end
        total++; if (goodA != 1) begin bad++; $display("FAIL single_good_pulses got=%0d want=1", goodA); end
        total++; if (aDepth !== 5'd0) begin bad++; $display("FAIL single_depth got=%0d want=0", aDepth); end
        total++; if (aFrames !== 5'd0) begin bad++; $display("FAIL single_frames got=%0d want=0", aFrames); end
    endtask

    task automatic test_backpressure();
        beat_t e;
        rxA.delete();
        for (int i = 0; i < 20; i++) txA.push_back(mk(16'h0100 + 16'(i), 2'b11, (i == 19), 8'h00, 8'h00, 1'b0));
        repeat (25) cycleA(1'b1, 1'b0);
        total++; if (txA.size() != 4) begin bad++; $display("FAIL full_accepted got=%0d want=16", 20 - txA.size()); end
        total++; if (aSready !== 1'b0) begin bad++; $display("FAIL full_tready got=%b want=0", aSready); end
        total++; if (aDepth !== 5'd16) begin bad++; $display("FAIL full_depth got=%0d want=16", aDepth); end
        cycleA(1'b1, 1'b1);
        total++; if (aSready !== 1'b1) begin bad++; $display("FAIL unfull_tready got=%b want=1", aSready); end
        total++; if (aDepth !== 5'd15) begin bad++; $display("FAIL unfull_depth got=%0d want=15", aDepth); end
        for (int c = 0; c < 80 && rxA.size() < 20; c++) cycleA(1'b1, 1'b1);
        total++; if (rxA.size() != 20) begin bad++; $display("FAIL bp_count got=%0d want=20", rxA.size()); end
        for (int i = 0; i < rxA.size() && i < 20; i++) begin
            e = mk(16'h0100 + 16'(i), 2'b11, (i == 19), 8'h00, 8'h00, 1'b0);
            total++; if (rxA[i] !== e) begin bad++; $display("FAIL bp_beat[%0d] got=%h want=%h", i, rxA[i], e); end
        end
        total++; if (aDepth !== 5'd0) begin bad++; $display("FAIL bp_depth got=%0d want=0", aDepth); end
    endtask

    task automatic test_sidebands();
        beat_t e;
        rxA.delete();
        for (int i = 0; i < 12; i++)
            txA.push_back(mk(16'hA000 + 16'(i * 'h111), (i == 11) ? 2'b01 : 2'b11, (i % 4 == 3), 8'h5A, 8'h3C, 1'b1));
        for (int c = 0; c < 300 && rxA.size() < 12; c++)
            cycleA(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
        total++; if (rxA.size() != 12) begin bad++; $display("FAIL side_count got=%0d want=12", rxA.size()); end
        for (int i = 0; i < rxA.size() && i < 12; i++) begin
            e = mk(16'hA000 + 16'(i * 'h111), (i == 11) ? 2'b01 : 2'b11, (i % 4 == 3), 8'h5A, 8'h3C, 1'b1);
            total++; if (rxA[i] !== e) begin bad++; $display("FAIL side_beat[%0d] got=%h want=%h", i, rxA[i], e); end
        end
        total++; if (aFrames !== 5'd0) begin bad++; $display("FAIL side_frames got=%0d want=0", aFrames); end
    endtask

    task automatic test_frame_gate();
        beat_t e;
        rxB.delete(); goodB = 0;
        for (int i = 0; i < 3; i++) txB.push_back(mk({8'h00, 8'hC0 + 8'(i)}, 2'b01, (i == 2), 8'h00, 8'h00, (i == 0)));
        cycleB(1'b1, 1'b1);
        total++; if (bMvalid !== 1'b0) begin bad++; $display("FAIL gate_valid_b0 got=%b want=0", bMvalid); end
        cycleB(1'b1, 1'b1);
        total++; if (bDepth !== 5'd2) begin bad++; $display("FAIL gate_depth got=%0d want=2", bDepth); end
        for (int k = 0; k < 5; k++) begin
            cycleB(1'b0, 1'b1);
            total++; if (bMvalid !== 1'b0) begin bad++; $display("FAIL gate_valid_idle%0d got=%b want=0", k, bMvalid); end
        end
        cycleB(1'b1, 1'b1);
        total++; if (bMvalid !== 1'b1) begin bad++; $display("FAIL gate_valid_after_last got=%b want=1", bMvalid); end
        total++; if (bFrames !== 5'd1) begin bad++; $display("FAIL gate_frames got=%0d want=1", bFrames); end
        repeat (3) cycleB(1'b0, 1'b1);
        total++; if (rxB.size() != 3) begin bad++; $display("FAIL gate_b2b_count got=%0d want=3", rxB.size()); end
        for (int i = 0; i < rxB.size() && i < 3; i++) begin
            e = mk({8'h00, 8'hC0 + 8'(i)}, 2'b01, (i == 2), 8'h00, 8'h00, (i == 0));
            total++; if (rxB[i] !== e) begin bad++; $display("FAIL gate_beat[%0d] got=%h want=%h", i, rxB[i], e); end
        end
        cycleB(1'b0, 1'b1);
        total++; if (goodB != 1) begin bad++; $display("FAIL gate_good_pulses got=%0d want=1", goodB); end
        total++; if (bFrames !== 5'd0) begin bad++; $display("FAIL gate_frames_end got=%0d want=0", bFrames); end
    endtask

    task automatic test_long_frame();
        beat_t e;
        rxB.delete();
        for (int i = 0; i < 24; i++) txB.push_back(mk({8'h00, 8'h40 + 8'(i)}, 2'b01, (i == 23), 8'h00, 8'h00, 1'b0));
        repeat (16) cycleB(1'b1, 1'b1);
        total++; if (bMvalid !== 1'b1) begin bad++; $display("FAIL long_override_valid got=%b want=1", bMvalid); end
        total++; if (bSready !== 1'b0) begin bad++; $display("FAIL long_full_tready got=%b want=0", bSready); end
        total++; if (bDepth !== 5'd16) begin bad++; $display("FAIL long_full_depth got=%0d want=16", bDepth); end
        for (int c = 0; c < 400 && rxB.size() < 24; c++) cycleB(1'b1, 1'b1);
        total++; if (rxB.size() != 24) begin bad++; $display("FAIL long_count got=%0d want=24", rxB.size()); end
        for (int i = 0; i < rxB.size() && i < 24; i++) begin
            e = mk({8'h00, 8'h40 + 8'(i)}, 2'b01, (i == 23), 8'h00, 8'h00, 1'b0);
            total++; if (rxB[i] !== e) begin bad++; $display("FAIL long_beat[%0d] got=%h want=%h", i, rxB[i], e); end
        end
        total++; if (bDepth !== 5'd0) begin bad++; $display("FAIL long_depth got=%0d want=0", bDepth); end
        total++; if (bFrames !== 5'd0) begin bad++; $display("FAIL long_frames got=%0d want=0", bFrames); end
    endtask

    task automatic test_reset_midstream();
        beat_t e;
        rxA.delete(); goodA = 0;
        for (int i = 0; i < 5; i++) txA.push_back(mk(16'h0500 + 16'(i), 2'b11, (i == 4), 8'h5A, 8'h3C, 1'b1));
        repeat (5) cycleA(1'b1, 1'b0);
        total++; if (aDepth !== 5'd5) begin bad++; $display("FAIL mid_depth_before got=%0d want=5", aDepth); end
        total++; if (aFrames !== 5'd1) begin bad++; $display("FAIL mid_frames_before got=%0d want=1", aFrames); end
        aSvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (aDepth !== 5'd0) begin bad++; $display("FAIL mid_depth_reset got=%0d want=0", aDepth); end
        total++; if (aFrames !== 5'd0) begin bad++; $display("FAIL mid_frames_reset got=%0d want=0", aFrames); end
        total++; if (aMvalid !== 1'b0) begin bad++; $display("FAIL mid_valid_reset got=%b want=0", aMvalid); end
        rst = 1'b0;
        cycleA(1'b0, 1'b1);
        total++; if (aMvalid !== 1'b0) begin bad++; $display("FAIL mid_valid_after got=%b want=0", aMvalid); end
        total++; if (rxA.size() != 0) begin bad++; $display("FAIL mid_stale_beats got=%0d want=0", rxA.size()); end
        e = mk(16'hBEEF, 2'b11, 1'b1, 8'h11, 8'h22, 1'b1);
        txA.push_back(e);
        for (int c = 0; c < 10 && rxA.size() < 1; c++) cycleA(1'b1, 1'b1);
        cycleA(1'b0, 1'b1);
        total++; if (rxA.size() != 1) begin bad++; $display("FAIL mid_new_count got=%0d want=1", rxA.size()); end
        if (rxA.size() != 0) begin
            total++; if (rxA[0] !== e) begin bad++; $display("FAIL mid_new_beat got=%h want=%h", rxA[0], e); end
        end
        total++; if (goodA != 1) begin bad++; $display("FAIL mid_new_good got=%0d want=1", goodA); end
    endtask

    initial begin
        rst = 1'b1;
        aSvalid = 1'b0; aSdata = '0; aSkeep = '0; aSlast = 1'b0; aSid = '0; aSdest = '0; aSuser = 1'b0; aMready = 1'b0;
        bSvalid = 1'b0; bSdata = '0; bSkeep = 1'b0; bSlast = 1'b0; bSid = '0; bSdest = '0; bSuser = 1'b0; bMready = 1'b0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_sidebands();
        test_frame_gate();
        test_long_frame();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule
